// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO register owner with iterative multiply/divide sequencer
module hilo_muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  state_t          state;
  logic [31:0]     mag_a;   // multiplicand / dividend (shifted left while dividing)
  logic [31:0]     mag_b;   // multiplier (shifted right while multiplying) / divisor
  logic [63:0]     acc;     // product, or {remainder, quotient} while dividing
  logic [CW-1:0]   cnt;
  logic            neg_a;
  logic            neg_b;
  logic            is_div;
  logic            div0;

  logic [32:0]     msum;
  logic [32:0]     rem_sh;
  logic            nonneg;
  logic [31:0]     diff;
  logic [63:0]     prod_fix;
  logic [31:0]     quo_fix;
  logic [31:0]     rem_fix;
  logic            is_signed;

  assign busy      = (state != IDLE);
  assign is_signed = (op_code == 3'd0) || (op_code == 3'd2);

  // One shift-add / restoring-divide step plus the sign fix-up applied at the end
  always_comb begin
    msum     = {1'b0, acc[63:32]} + (mag_b[0] ? {1'b0, mag_a} : 33'd0);
    rem_sh   = {acc[63:32], mag_a[31]};
    nonneg   = (rem_sh >= {1'b0, mag_b});
    diff     = rem_sh[31:0] - mag_b;
    prod_fix = (neg_a ^ neg_b) ? (~acc + 64'd1) : acc;
    quo_fix  = div0 ? 32'hFFFF_FFFF
                    : ((neg_a ^ neg_b) ? (~acc[31:0] + 32'd1) : acc[31:0]);
    rem_fix  = neg_a ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // Sequencer: accept, iterate ITER steps, fix up signs and write HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi_out <= 32'd0;
      lo_out <= 32'd0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= 64'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      is_div <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                neg_a  <= is_signed & rs_val[31];
                neg_b  <= is_signed & rt_val[31];
                mag_a  <= (is_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
                mag_b  <= (is_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
                is_div <= op_code[1];
                div0   <= op_code[1] && (rt_val == 32'd0);
                acc    <= 64'd0;
                cnt    <= CW'(ITER);
                state  <= op_code[1] ? DIV : MUL;
              end
              3'd4:    hi_out <= rs_val;
              3'd5:    lo_out <= rs_val;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc   <= {msum, acc[31:1]};
          mag_b <= mag_b >> 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIXUP;
        end
        DIV: begin
          acc   <= {(nonneg ? diff : rem_sh[31:0]), acc[30:0], nonneg};
          mag_a <= mag_a << 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            hi_out <= rem_fix;
            lo_out <= quo_fix;
          end else begin
            hi_out <= prod_fix[63:32];
            lo_out <= prod_fix[31:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  hilo_muldiv_ctrl #(.ITER(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .done     (done),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {HI, LO} from plain wide arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue a mul/div at the current negedge; returns at the negedge where done should be high
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject_mtlo);
    logic [63:0] exp;
    int n;
    exp      = ref_model(op, a, b);
    op_valid = 1'b1;
    op_code  = op;
    rs_val   = a;
    rt_val   = b;
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      rs_val = $urandom;
      rt_val = $urandom;
      if (inject_mtlo && n == 5) begin
        op_valid = 1'b1;
        op_code  = 3'd5;
      end else begin
        op_valid = 1'b0;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi_out), 64'(exp[63:32]));
    check({tag, " lo"}, 64'(lo_out), 64'(exp[31:0]));
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  task automatic done_low(input string tag);
    @(negedge clk);
    check({tag, " done_pulse_end"}, 64'(done), 64'd0);
  endtask

  // MTHI/MTLO/no-op issued at the current negedge
  task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] a);
    op_valid = 1'b1;
    op_code  = op;
    rs_val   = a;
    @(negedge clk);
    op_valid = 1'b0;
    if (op == 3'd4) hi_m = a;
    if (op == 3'd5) lo_m = a;
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " hi"}, 64'(hi_out), 64'(hi_m));
    check({tag, " lo"}, 64'(lo_out), 64'(lo_m));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'd7;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    hi_m     = 32'd0;
    lo_m     = 32'd0;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(hi_out), 64'd0);
    check("reset lo", 64'(lo_out), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    done_low("mult_neg3x7");

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("multu_b2b", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    done_low("multu_b2b");

    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_5_0", 3'd3, 32'd5, 32'd0, 1'b0);
    done_low("divu_5_0");
    run_op("div_neg_0", 3'd2, 32'h8000_0005, 32'd0, 1'b0);
    @(negedge clk);

    mt_op("mthi", 3'd4, 32'h1234_5678);
    mt_op("mtlo", 3'd5, 32'h0000_5555);
    mt_op("noop6", 3'd6, 32'hDEAD_BEEF);
    mt_op("noop7", 3'd7, 32'hCAFE_F00D);

    run_op("mult_mtlo_ignored", 3'd0, 32'h0000_1234, 32'hFFFF_5678, 1'b1);
    done_low("mult_mtlo_ignored");

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (rop < 3'd4) begin
        run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0);
        @(negedge clk);
      end else begin
        mt_op($sformatf("rand%0d_op%0d", i, rop), rop, ra);
      end
    end

    op_valid = 1'b1;
    op_code  = 3'd2;
    rs_val   = 32'hFFFF_0000;
    rt_val   = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("middiv busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst hi", 64'(hi_out), 64'd0);
    check("async_rst lo", 64'(lo_out), 64'd0);
    check("async_rst busy", 64'(busy), 64'd0);
    check("async_rst done", 64'(done), 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst busy", 64'(busy), 64'd0);
    run_op("post_rst_divu", 3'd3, 32'd1000, 32'd33, 1'b0);
    done_low("post_rst_divu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
